// File: rtl/glb_ld_dma_sched.sv
// rtl/glb_ld_dma_sched.sv - GLB load DMA scheduler: nested-loop read address generator with burst gaps and repeat.
module glb_ld_dma_sched #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int LOOP_LEVEL          = 3,
  parameter int MAX_NUM_WORDS_WIDTH = 16,
  parameter int MAX_STRIDE_WIDTH    = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [1:0]                                  mode,
  input  logic                                        start_pulse,
  input  logic [GLB_ADDR_WIDTH-1:0]                   hdr_start_addr,
  input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0]   hdr_range,
  input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]      hdr_stride,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]              hdr_num_active_words,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]              hdr_num_inactive_words,
  output logic                                        rdrq_rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]                   rdrq_rd_addr,
  input  logic                                        rdrq_ready,
  input  logic [BANK_DATA_WIDTH-1:0]                  rdrs_rd_data,
  input  logic                                        rdrs_rd_data_valid,
  output logic [BANK_DATA_WIDTH-1:0]                  stream_data,
  output logic                                        stream_data_valid,
  output logic                                        busy,
  output logic                                        done_pulse
);
  localparam int MW = MAX_NUM_WORDS_WIDTH;
  localparam int SW = MAX_STRIDE_WIDTH;
  localparam int AW = GLB_ADDR_WIDTH;
  localparam int PW = MW + SW;
  localparam logic [MW-1:0] ONE_W = 1;
  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [AW-1:0]           start_q, start_d;
  logic [LOOP_LEVEL*MW-1:0] range_q, range_d;
  logic [LOOP_LEVEL*SW-1:0] stride_q, stride_d;
  logic [MW-1:0]           active_q, active_d;
  logic [MW-1:0]           inactive_q, inactive_d;
  logic [MW-1:0]           burst_q, burst_d;
  logic [MW-1:0]           gap_q, gap_d;
  logic [MW-1:0]           itr_q [LOOP_LEVEL];
  logic [MW-1:0]           itr_d [LOOP_LEVEL];
  logic [MW-1:0]           itr_inc [LOOP_LEVEL];
  logic                    rd_en_q, rd_en_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic [BANK_DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                    svalid_q, svalid_d;

  logic                    last_q, zero_q, hdr_zero, carry;
  logic [MW-1:0]           rng;
  logic [PW-1:0]           prod;
  logic [AW-1:0]           addr_acc;

  // Iterator increment with cascading wrap, plus pass-end and empty-range detection.
  always_comb begin
    last_q   = 1'b1;
    zero_q   = 1'b0;
    hdr_zero = 1'b0;
    carry    = 1'b1;
    rng      = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      rng = range_q[i*MW +: MW];
      if (itr_q[i] != rng - ONE_W) last_q = 1'b0;
      if (rng == '0) zero_q = 1'b1;
      if (hdr_range[i*MW +: MW] == '0) hdr_zero = 1'b1;
      itr_inc[i] = itr_q[i];
      if (carry) begin
        if (itr_q[i] == rng - ONE_W) begin
          itr_inc[i] = '0;
        end else begin
          itr_inc[i] = itr_q[i] + ONE_W;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    start_d    = start_q;
    range_d    = range_q;
    stride_d   = stride_q;
    active_d   = active_q;
    inactive_d = inactive_q;
    burst_d    = burst_q;
    gap_d      = gap_q;
    rd_en_d    = rd_en_q;
    done_d     = 1'b0;
    for (int i = 0; i < LOOP_LEVEL; i++) itr_d[i] = itr_q[i];

    case (state_q)
      IDLE: begin
        if (start_pulse && mode != MODE_OFF) begin
          mode_d     = mode;
          start_d    = hdr_start_addr;
          range_d    = hdr_range;
          stride_d   = hdr_stride;
          active_d   = hdr_num_active_words;
          inactive_d = hdr_num_inactive_words;
          for (int i = 0; i < LOOP_LEVEL; i++) itr_d[i] = '0;
          burst_d    = '0;
          state_d    = RUN;
          rd_en_d    = !hdr_zero;
        end
      end
      RUN: begin
        if (zero_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          rd_en_d = 1'b0;
        end else if (rd_en_q && rdrq_ready) begin
          for (int i = 0; i < LOOP_LEVEL; i++) itr_d[i] = itr_inc[i];
          if (last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            rd_en_d = 1'b0;
          end else if (active_q != '0 && inactive_q != '0 && burst_q == active_q - ONE_W) begin
            state_d = GAP;
            gap_d   = '0;
            burst_d = '0;
            rd_en_d = 1'b0;
          end else begin
            burst_d = burst_q + ONE_W;
          end
        end
      end
      GAP: begin
        if (gap_q == inactive_q - ONE_W) begin
          state_d = RUN;
          rd_en_d = 1'b1;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + ONE_W;
        end
      end
      DONE: begin
        // The live mode input can cancel a repeating schedule at the pass boundary.
        if (mode_q == MODE_REPEAT && mode != MODE_OFF) begin
          state_d = RUN;
          for (int i = 0; i < LOOP_LEVEL; i++) itr_d[i] = '0;
          burst_d = '0;
          rd_en_d = !zero_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    addr_acc = start_d;
    prod     = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      prod     = PW'(itr_d[i]) * PW'(stride_d[i*SW +: SW]);
      addr_acc = addr_acc + AW'(prod);
    end
    addr_d = addr_acc;

    busy_d   = (state_d != IDLE);
    svalid_d = rdrs_rd_data_valid;
    sdata_d  = rdrs_rd_data_valid ? rdrs_rd_data : sdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      start_q    <= '0;
      range_q    <= '0;
      stride_q   <= '0;
      active_q   <= '0;
      inactive_q <= '0;
      burst_q    <= '0;
      gap_q      <= '0;
      for (int i = 0; i < LOOP_LEVEL; i++) itr_q[i] <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      sdata_q    <= '0;
      svalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      range_q    <= range_d;
      stride_q   <= stride_d;
      active_q   <= active_d;
      inactive_q <= inactive_d;
      burst_q    <= burst_d;
      gap_q      <= gap_d;
      for (int i = 0; i < LOOP_LEVEL; i++) itr_q[i] <= itr_d[i];
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      sdata_q    <= sdata_d;
      svalid_q   <= svalid_d;
    end
  end

  assign rdrq_rd_en        = rd_en_q;
  assign rdrq_rd_addr      = addr_q;
  assign done_pulse        = done_q;
  assign busy              = busy_q;
  assign stream_data       = sdata_q;
  assign stream_data_valid = svalid_q;
endmodule

// File: tb/tb_glb_ld_dma_sched.sv
// tb/tb_glb_ld_dma_sched.sv - self-checking bench for glb_ld_dma_sched against a nested-loop address model.
module tb_glb_ld_dma_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        start_pulse;
  logic [21:0] hdr_start_addr;
  logic [47:0] hdr_range;
  logic [47:0] hdr_stride;
  logic [15:0] hdr_num_active_words;
  logic [15:0] hdr_num_inactive_words;
  logic        rdrq_rd_en;
  logic [21:0] rdrq_rd_addr;
  logic        rdrq_ready;
  logic [63:0] rdrs_rd_data;
  logic        rdrs_rd_data_valid;
  logic [63:0] stream_data;
  logic        stream_data_valid;
  logic        busy;
  logic        done_pulse;

  always #5 clk = ~clk;

  glb_ld_dma_sched dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .start_pulse(start_pulse),
    .hdr_start_addr(hdr_start_addr), .hdr_range(hdr_range), .hdr_stride(hdr_stride),
    .hdr_num_active_words(hdr_num_active_words), .hdr_num_inactive_words(hdr_num_inactive_words),
    .rdrq_rd_en(rdrq_rd_en), .rdrq_rd_addr(rdrq_rd_addr), .rdrq_ready(rdrq_ready),
    .rdrs_rd_data(rdrs_rd_data), .rdrs_rd_data_valid(rdrs_rd_data_valid),
    .stream_data(stream_data), .stream_data_valid(stream_data_valid),
    .busy(busy), .done_pulse(done_pulse)
  );

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];
  logic [21:0] acc_q[$];
  logic        en_q[$];
  logic        exp_en[$];
  int zero_cycles;
  int rng[3];
  int str[3];
  int start_a, act, inact;
  logic [63:0] exp_data, d;
  logic v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hdr(input int sa, input int r0, input int r1, input int r2,
                         input int s0, input int s1, input int s2, input int a, input int ia);
    start_a = sa; rng[0] = r0; rng[1] = r1; rng[2] = r2;
    str[0] = s0; str[1] = s1; str[2] = s2; act = a; inact = ia;
    hdr_start_addr = 22'(sa);
    hdr_range  = {16'(r2), 16'(r1), 16'(r0)};
    hdr_stride = {16'(s2), 16'(s1), 16'(s0)};
    hdr_num_active_words   = 16'(a);
    hdr_num_inactive_words = 16'(ia);
  endtask

  task automatic build_model();
    longint a;
    exp_q.delete();
    for (int i2 = 0; i2 < rng[2]; i2++)
      for (int i1 = 0; i1 < rng[1]; i1++)
        for (int i0 = 0; i0 < rng[0]; i0++) begin
          a = longint'(start_a) + longint'(i0) * str[0] + longint'(i1) * str[1] + longint'(i2) * str[2];
          exp_q.push_back(22'(a % 64'h400000));
        end
  endtask

  task automatic start_pass();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic collect(input int pct);
    acc_q.delete();
    en_q.delete();
    zero_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done_pulse) break;
      rdrq_ready = (int'($urandom_range(99)) < pct);
      en_q.push_back(rdrq_rd_en);
      if (rdrq_rd_en && rdrq_ready) acc_q.push_back(rdrq_rd_addr);
      if (!rdrq_rd_en) zero_cycles++;
      tick();
    end
    check("pass_done_seen", done_pulse, 1'b1);
    rdrq_ready = 1'b1;
  endtask

  task automatic compare_addrs(input string tag, input int offset);
    check({tag, "_count"}, acc_q.size() + offset, exp_q.size());
    for (int k = 0; k < acc_q.size() && k + offset < exp_q.size(); k++)
      check({tag, "_addr"}, acc_q[k], exp_q[k + offset]);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; start_pulse = 1'b0; rdrq_ready = 1'b1;
    rdrs_rd_data = '0; rdrs_rd_data_valid = 1'b0;
    set_hdr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rd_en", rdrq_rd_en, 0);
    check("rst_addr", rdrq_rd_addr, 0);
    check("rst_done", done_pulse, 0);
    check("rst_svalid", stream_data_valid, 0);
    check("rst_sdata", stream_data, 0);
    rst_n = 1'b1;
    tick();

    set_hdr('h100, 4, 2, 1, 8, 'h40, 0, 0, 0);
    start_pass();
    check("off_start_busy", busy, 0);
    check("off_start_en", rdrq_rd_en, 0);

    mode = 2'b01;
    build_model();
    start_pass();
    for (int k = 0; k < 8; k++) begin
      check("normal_en", rdrq_rd_en, 1);
      check("normal_addr", rdrq_rd_addr, exp_q[k]);
      if (k == 3) begin
        hdr_start_addr = 22'h2000;
        start_pulse = 1'b1;
      end else begin
        start_pulse = 1'b0;
      end
      tick();
    end
    start_pulse = 1'b0;
    hdr_start_addr = 22'h100;
    check("normal_done", done_pulse, 1);
    check("normal_done_en", rdrq_rd_en, 0);
    check("normal_done_busy", busy, 1);
    tick();
    check("normal_done_once", done_pulse, 0);
    check("normal_idle", busy, 0);

    start_pass();
    for (int k = 0; k < 2; k++) begin
      check("bp_pre_addr", rdrq_rd_addr, exp_q[k]);
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      check("bp_hold_en", rdrq_rd_en, 1);
      check("bp_hold_addr", rdrq_rd_addr, 22'h110);
      rdrq_ready = 1'b0;
      tick();
    end
    check("bp_hold_en4", rdrq_rd_en, 1);
    check("bp_hold_addr4", rdrq_rd_addr, 22'h110);
    collect(100);
    compare_addrs("bp", 2);
    check("bp_accepts", 2 + acc_q.size(), 8);
    tick();

    set_hdr(0, 7, 1, 1, 4, 0, 0, 3, 2);
    build_model();
    exp_en.delete();
    for (int j = 0; j < 7; j++) begin
      exp_en.push_back(1'b1);
      if (j % 3 == 2 && j != 6) begin
        exp_en.push_back(1'b0);
        exp_en.push_back(1'b0);
      end
    end
    start_pass();
    collect(100);
    compare_addrs("gap", 0);
    check("gap_pattern_len", en_q.size(), exp_en.size());
    for (int k = 0; k < en_q.size() && k < exp_en.size(); k++)
      check("gap_pattern", en_q[k], exp_en[k]);
    tick();
    check("gap_idle", busy, 0);

    mode = 2'b10;
    set_hdr('h200, 2, 1, 1, 'h10, 0, 0, 0, 0);
    start_pass();
    check("rep_a0", rdrq_rd_addr, 22'h200);
    check("rep_a0_en", rdrq_rd_en, 1);
    tick();
    check("rep_a1", rdrq_rd_addr, 22'h210);
    tick();
    check("rep_done1", done_pulse, 1);
    check("rep_done1_en", rdrq_rd_en, 0);
    tick();
    check("rep_b0_en", rdrq_rd_en, 1);
    check("rep_b0", rdrq_rd_addr, 22'h200);
    check("rep_b0_done", done_pulse, 0);
    mode = 2'b00;
    tick();
    check("rep_b1", rdrq_rd_addr, 22'h210);
    tick();
    check("rep_done2", done_pulse, 1);
    tick();
    check("rep_off_idle", busy, 0);
    check("rep_off_en", rdrq_rd_en, 0);
    check("rep_off_done", done_pulse, 0);

    mode = 2'b01;
    set_hdr('h100, 4, 0, 1, 8, 'h40, 0, 0, 0);
    start_pass();
    check("zr_c1_en", rdrq_rd_en, 0);
    check("zr_c1_busy", busy, 1);
    check("zr_c1_done", done_pulse, 0);
    tick();
    check("zr_c2_done", done_pulse, 1);
    check("zr_c2_en", rdrq_rd_en, 0);
    tick();
    check("zr_idle", busy, 0);

    set_hdr('h3FFFF8, 2, 1, 1, 8, 0, 0, 0, 0);
    build_model();
    start_pass();
    collect(100);
    compare_addrs("wrap", 0);
    tick();

    set_hdr('h100, 4, 2, 1, 8, 'h40, 0, 0, 0);
    build_model();
    rdrs_rd_data = 64'hDEAD_BEEF; rdrs_rd_data_valid = 1'b1;
    start_pass();
    tick(); tick();
    rst_n = 1'b0;
    rdrs_rd_data_valid = 1'b0;
    tick();
    check("mrst_en", rdrq_rd_en, 0);
    check("mrst_addr", rdrq_rd_addr, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done_pulse, 0);
    check("mrst_svalid", stream_data_valid, 0);
    check("mrst_sdata", stream_data, 0);
    rst_n = 1'b1;
    tick();
    check("mrst_no_done", done_pulse, 0);
    start_pass();
    collect(100);
    compare_addrs("mrst_restart", 0);
    tick();

    for (int t = 0; t < 6; t++) begin
      int sa, n, gaps;
      sa = (t % 2 == 0) ? int'($urandom_range(32'h3FFFFF)) : 'h3FFF00 + int'($urandom_range(255));
      set_hdr(sa, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
              int'($urandom_range(255)), int'($urandom_range(1023)), int'($urandom_range(4095)),
              int'($urandom_range(3)), int'($urandom_range(3)));
      mode = (t % 3 == 0) ? 2'b11 : 2'b01;
      build_model();
      n = exp_q.size();
      gaps = (act != 0 && inact != 0) ? ((n - 1) / act) * inact : 0;
      start_pass();
      collect(70);
      compare_addrs("rand", 0);
      check("rand_gap_cycles", zero_cycles, gaps);
      tick();
      check("rand_idle", busy, 0);
    end

    exp_data = '0;
    for (int k = 0; k < 16; k++) begin
      v = 1'($urandom_range(1));
      d = {$urandom, $urandom};
      rdrs_rd_data = d;
      rdrs_rd_data_valid = v;
      tick();
      if (v) exp_data = d;
      check("stream_valid", stream_data_valid, v);
      check("stream_data", stream_data, exp_data);
    end
    rdrs_rd_data_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
